// File: rtl/mda_vram_arbiter.sv
// mda_vram_arbiter
//   Shares one synchronous single-port VRAM between the MDA display fetch and
//   the ISA CPU port. The display owns the RAM whenever the sequencer raises
//   vram_read. ISA accesses start only inside the sequencer's ISA window and
//   run a fixed IDLE->OP1->OP2->ACK->REL handshake.
// Ports
//   clk, reset          pixel clock; asynchronous active-high reset
//   vram_read*          sequencer strobes for the char/attr fetch
//   isa_op_enable       sequencer strobe: an ISA op may be accepted this cycle
//   crtc_addr           CRTC character address (word address of the char/attr pair)
//   isa_req/wr/addr/din ISA request, level-held until isa_ack
//   isa_dout, isa_ack   ISA read data and one-cycle completion pulse
//   ram_addr/dout/we    VRAM controls; ram_din is read data one cycle after ram_addr
//   char_byte/att_byte  latched fetch pair; fetch_valid pulses when it updates
//   collision_err       sticky flag: an ISA op overlapped a display fetch
module mda_vram_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vram_read,
  input  logic              vram_read_a0,
  input  logic              vram_read_char,
  input  logic              vram_read_att,
  input  logic              isa_op_enable,
  input  logic [ADDR_W-2:0] crtc_addr,
  input  logic              isa_req,
  input  logic              isa_wr,
  input  logic [ADDR_W-1:0] isa_addr,
  input  logic [7:0]        isa_din,
  output logic [7:0]        isa_dout,
  output logic              isa_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              ram_we,
  input  logic [7:0]        ram_din,
  output logic [7:0]        char_byte,
  output logic [7:0]        att_byte,
  output logic              fetch_valid,
  output logic              collision_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OP1  = 3'd1,
    OP2  = 3'd2,
    ACK  = 3'd3,
    REL  = 3'd4
  } state_t;

  state_t            state_r;
  logic              wr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        din_r;
  logic [7:0]        isa_dout_r;
  logic              isa_ack_r;
  logic              collision_r;
  logic [7:0]        char_q_r;
  logic [7:0]        char_byte_r;
  logic [7:0]        att_byte_r;
  logic              fetch_valid_r;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [7:0]        ram_dout_s;
  logic              ram_we_s;

  // Display fetch: hold the char byte until the attr byte arrives so the pair updates together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char_q_r      <= 8'h00;
      char_byte_r   <= 8'h00;
      att_byte_r    <= 8'h00;
      fetch_valid_r <= 1'b0;
    end else begin
      fetch_valid_r <= 1'b0;
      if (vram_read_char) begin
        char_q_r <= ram_din;
      end
      if (vram_read_att) begin
        char_byte_r   <= char_q_r;
        att_byte_r    <= ram_din;
        fetch_valid_r <= 1'b1;
      end
    end
  end

  // ISA handshake FSM with its latched request, read data, ack pulse and collision flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      wr_r        <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      din_r       <= 8'h00;
      isa_dout_r  <= 8'h00;
      isa_ack_r   <= 1'b0;
      collision_r <= 1'b0;
    end else begin
      isa_ack_r <= 1'b0;
      // Display always wins the port; an overlapping ISA op is flagged, not stalled
      if (((state_r == OP1) || (state_r == OP2)) && vram_read) begin
        collision_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (isa_req && isa_op_enable) begin
            wr_r    <= isa_wr;
            addr_r  <= isa_addr;
            din_r   <= isa_din;
            state_r <= OP1;
          end
        end
        OP1: begin
          state_r <= OP2;
        end
        OP2: begin
          // ram_din now carries the data for the address presented in OP1
          if (!wr_r) begin
            isa_dout_r <= ram_din;
          end
          isa_ack_r <= 1'b1;
          state_r   <= ACK;
        end
        ACK: begin
          state_r <= REL;
        end
        REL: begin
          // Wait for the requester to drop so a held request is not executed twice
          if (!isa_req) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // VRAM port mux: display address has priority over the ISA op, which is otherwise parked at 0
  always_comb begin
    ram_addr_s = {ADDR_W{1'b0}};
    ram_dout_s = 8'h00;
    ram_we_s   = 1'b0;
    if (vram_read) begin
      ram_addr_s = {crtc_addr, vram_read_a0};
    end else begin
      case (state_r)
        OP1: begin
          ram_addr_s = addr_r;
          ram_dout_s = din_r;
          ram_we_s   = wr_r;
        end
        OP2: begin
          ram_addr_s = addr_r;
        end
        default: begin
          ram_addr_s = {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  assign ram_addr      = ram_addr_s;
  assign ram_dout      = ram_dout_s;
  assign ram_we        = ram_we_s;
  assign isa_dout      = isa_dout_r;
  assign isa_ack       = isa_ack_r;
  assign char_byte     = char_byte_r;
  assign att_byte      = att_byte_r;
  assign fetch_valid   = fetch_valid_r;
  assign collision_err = collision_r;

endmodule

// File: tb/tb_mda_vram_arbiter.sv
// tb_mda_vram_arbiter
//   Drives an 18-cycle character slot (display fetch at seq 1..4, ISA window
//   at seq 6..15) against a behavioural synchronous VRAM. Expected fetch pairs
//   and ISA read results are queued when stimulus is applied and compared when
//   fetch_valid / isa_ack appear.
module tb_mda_vram_arbiter;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              vram_read, vram_read_a0, vram_read_char, vram_read_att, isa_op_enable;
  logic [ADDR_W-2:0] crtc_addr;
  logic              isa_req, isa_wr;
  logic [ADDR_W-1:0] isa_addr;
  logic [7:0]        isa_din, isa_dout;
  logic              isa_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout, ram_din;
  logic              ram_we;
  logic [7:0]        char_byte, att_byte;
  logic              fetch_valid, collision_err;

  mda_vram_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .vram_read(vram_read), .vram_read_a0(vram_read_a0),
    .vram_read_char(vram_read_char), .vram_read_att(vram_read_att),
    .isa_op_enable(isa_op_enable), .crtc_addr(crtc_addr),
    .isa_req(isa_req), .isa_wr(isa_wr), .isa_addr(isa_addr), .isa_din(isa_din),
    .isa_dout(isa_dout), .isa_ack(isa_ack),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_we(ram_we), .ram_din(ram_din),
    .char_byte(char_byte), .att_byte(att_byte),
    .fetch_valid(fetch_valid), .collision_err(collision_err)
  );

  always #5 clk = ~clk;

  // Behavioural single-port VRAM: read-first, one-cycle read latency
  logic [7:0] vram [0:4095];
  logic       mem_load;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 4096; i++) vram[i] <= 8'h00;
      vram[12'h020] <= 8'h41;
      vram[12'h021] <= 8'h07;
    end else begin
      if (ram_we) vram[ram_addr] <= ram_dout;
    end
    ram_din <= vram[ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int seq;
  bit force_en;
  logic [15:0] fetch_q [$];
  logic [8:0]  ack_q [$];   // bit 8 set: read data is don't-care
  int ack_cnt, first_ack_seq, we_cnt, we_seq;
  logic [ADDR_W-1:0] we_addr, addr_at_seq1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_seq();
    vram_read      = (seq >= 1) && (seq <= 4);
    vram_read_a0   = (seq >= 3) && (seq <= 4);
    vram_read_char = (seq == 2);
    vram_read_att  = (seq == 4);
    isa_op_enable  = ((seq >= 6) && (seq <= 15)) || (force_en && (seq == 0));
  endtask

  // Advance one cycle, apply the sequencer strobes, then observe the DUT
  task automatic tick();
    logic [15:0] fe;
    logic [8:0]  ae;
    @(posedge clk);
    #1;
    seq = (seq == 17) ? 0 : seq + 1;
    drive_seq();
    if (seq == 1 && !reset) fetch_q.push_back({8'h41, 8'h07});
    #1;
    if (seq == 1) addr_at_seq1 = ram_addr;
    if (ram_we) begin
      we_cnt++;
      we_addr = ram_addr;
      we_seq  = seq;
    end
    if (isa_ack) begin
      if (ack_cnt == 0) first_ack_seq = seq;
      ack_cnt++;
      if (ack_q.size() == 0) begin
        check_eq("unexpected_isa_ack", 32'(isa_ack), 32'(1'b0));
      end else begin
        ae = ack_q.pop_front();
        if (!ae[8]) check_eq("isa_dout_at_ack", 32'(isa_dout), 32'(ae[7:0]));
      end
    end
    if (fetch_valid) begin
      if (fetch_q.size() == 0) begin
        check_eq("unexpected_fetch_valid", 32'(fetch_valid), 32'(1'b0));
      end else begin
        fe = fetch_q.pop_front();
        check_eq("char_byte", 32'(char_byte), 32'(fe[15:8]));
        check_eq("att_byte", 32'(att_byte), 32'(fe[7:0]));
        check_eq("fetch_valid_seq", 32'(seq), 32'd5);
      end
    end
  endtask

  task automatic tick_to(input int s);
    for (int i = 0; i < 18; i++) begin
      tick();
      if (seq == s) break;
    end
  endtask

  // One ISA op: request, wait (bounded) for ack, hold req `hold` more cycles, release
  task automatic isa_txn(input logic wr, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                         input logic [8:0] exp, input int hold);
    we_cnt = 0;
    ack_cnt = 0;
    first_ack_seq = -1;
    ack_q.push_back(exp);
    isa_req = 1'b1; isa_wr = wr; isa_addr = a; isa_din = d;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ack_cnt != 0) break;
    end
    check_eq("isa_ack_seen", 32'(ack_cnt), 32'd1);
    repeat (hold) tick();
    isa_req = 1'b0; isa_wr = 1'b0; isa_addr = '0; isa_din = 8'h00;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; mem_load = 1'b1; force_en = 1'b0; seq = 17;
    vram_read = 1'b0; vram_read_a0 = 1'b0; vram_read_char = 1'b0; vram_read_att = 1'b0;
    isa_op_enable = 1'b0; crtc_addr = 11'h010;
    isa_req = 1'b0; isa_wr = 1'b0; isa_addr = '0; isa_din = 8'h00;
    ack_cnt = 0; we_cnt = 0; first_ack_seq = -1; we_seq = -1; we_addr = '0; addr_at_seq1 = '0;
    repeat (3) @(posedge clk);
    #1;
    mem_load = 1'b0;
    // Reset state
    check_eq("rst_isa_ack", 32'(isa_ack), 32'd0);
    check_eq("rst_isa_dout", 32'(isa_dout), 32'd0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("rst_ram_dout", 32'(ram_dout), 32'd0);
    check_eq("rst_char_att", 32'({char_byte, att_byte}), 32'd0);
    check_eq("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check_eq("rst_collision", 32'(collision_err), 32'd0);
    reset = 1'b0;

    // 1: display fetch of one slot
    tick_to(1);
    check_eq("fetch_addr_even", 32'(ram_addr), 32'h020);
    tick_to(3);
    check_eq("fetch_addr_odd", 32'(ram_addr), 32'h021);
    tick_to(6);
    check_eq("fetch_queue_drained", 32'(fetch_q.size()), 32'd0);

    // 2: ISA write accepted at seq 7
    tick_to(7);
    isa_txn(1'b1, 12'h155, 8'hA5, 9'h100, 0);
    check_eq("wr_we_count", 32'(we_cnt), 32'd1);
    check_eq("wr_we_addr", 32'(we_addr), 32'h155);
    check_eq("wr_we_seq", 32'(we_seq), 32'd8);
    check_eq("wr_ack_seq", 32'(first_ack_seq), 32'd10);
    check_eq("wr_vram", 32'(vram[12'h155]), 32'h0A5);

    // 3: ISA read back, request held 5 extra cycles
    isa_txn(1'b0, 12'h155, 8'h00, 9'h0A5, 5);
    check_eq("rd_single_ack", 32'(ack_cnt), 32'd1);
    check_eq("rd_no_we", 32'(we_cnt), 32'd0);
    check_eq("rd_dout_held", 32'(isa_dout), 32'h0A5);

    // 4: window boundaries
    tick_to(1);
    isa_txn(1'b0, 12'h021, 8'h00, 9'h007, 0);
    check_eq("win_early_ack_seq", 32'(first_ack_seq), 32'd9);
    tick_to(15);
    isa_txn(1'b1, 12'h300, 8'h5A, 9'h100, 0);
    check_eq("win_late_we_seq", 32'(we_seq), 32'd16);
    check_eq("win_late_ack_seq", 32'(first_ack_seq), 32'd0);
    check_eq("win_late_vram", 32'(vram[12'h300]), 32'h05A);
    check_eq("win_no_collision", 32'(collision_err), 32'd0);
    check_eq("win_dout_after_write", 32'(isa_dout), 32'h007);

    // 5: forced accept at seq 0 collides with the display fetch
    tick_to(17);
    force_en = 1'b1;
    isa_txn(1'b1, 12'h301, 8'h33, 9'h100, 0);
    force_en = 1'b0;
    check_eq("col_no_we", 32'(we_cnt), 32'd0);
    check_eq("col_display_addr", 32'(addr_at_seq1), 32'h020);
    check_eq("col_ack_seq", 32'(first_ack_seq), 32'd3);
    check_eq("col_vram_untouched", 32'(vram[12'h301]), 32'h000);
    tick_to(12);
    check_eq("col_sticky", 32'(collision_err), 32'd1);

    // 6: reset during OP1 of a write
    tick_to(7);
    ack_cnt = 0;
    isa_req = 1'b1; isa_wr = 1'b1; isa_addr = 12'h155; isa_din = 8'h77;
    tick();
    check_eq("rst_op1_we", 32'(ram_we), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rst_mid_we", 32'(ram_we), 32'd0);
    check_eq("rst_mid_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_mid_dout", 32'(ram_dout), 32'd0);
    check_eq("rst_mid_outs", 32'({isa_ack, isa_dout, char_byte, att_byte, fetch_valid, collision_err}), 32'd0);
    tick();
    isa_req = 1'b0; isa_wr = 1'b0;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check_eq("rst_no_ack", 32'(ack_cnt), 32'd0);
    check_eq("rst_vram_unchanged", 32'(vram[12'h155]), 32'h0A5);
    tick_to(6);
    isa_txn(1'b0, 12'h155, 8'h00, 9'h0A5, 0);
    check_eq("post_rst_ack_seq", 32'(first_ack_seq), 32'd9);
    check_eq("post_rst_no_collision", 32'(collision_err), 32'd0);
    tick_to(6);
    check_eq("ack_queue_empty", 32'(ack_q.size()), 32'd0);
    check_eq("fetch_queue_empty", 32'(fetch_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
